// File: rtl/result_display_ctrl.sv
// Multi-digit result history with a time-multiplexed 7-segment driver,
// a debounced history/status mode switch and a free-running heartbeat.
module result_display_ctrl #(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned HB_DIV          = 25000000,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              result_valid,
    input  logic [3:0]                        result_in,
    input  logic [3:0]                        status_code,
    input  logic                              clear,
    input  logic                              mode_sw,
    output logic [6:0]                        seg,
    output logic [NUM_DIGITS-1:0]             an,
    output logic                              heartbeat,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   history_count
);

    localparam int unsigned IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PSW  = $clog2(SCAN_DIV);
    localparam int unsigned HBW  = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam int unsigned DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned CNTW = $clog2(NUM_DIGITS+1);

    localparam logic [6:0]            SEG_BLANK = 7'b1111111;
    localparam logic [6:0]            SEG_DASH  = 7'b0111111;
    localparam logic [6:0]            SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    typedef enum logic {
        MODE_HISTORY = 1'b0,
        MODE_STATUS  = 1'b1
    } mode_e;

    // Active-low segment pattern for a hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ---------------- mode switch synchronizer + debounce ----------------
    logic           sw_meta_q, sw_sync_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    mode_e          mode_q, mode_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= 1'b0;
            sw_sync_q <= 1'b0;
        end else begin
            sw_meta_q <= mode_sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_HISTORY;
            db_cnt_q <= '0;
        end else begin
            mode_q   <= mode_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        db_cnt_d = '0;
        if (sw_sync_q != logic'(mode_q)) begin
            if (db_cnt_q == DBW'(DEBOUNCE_CYCLES-1)) begin
                mode_d   = (mode_q == MODE_HISTORY) ? MODE_STATUS : MODE_HISTORY;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- result history ----------------
    logic [3:0]            ent_q [NUM_DIGITS];
    logic [3:0]            ent_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] vld_q, vld_d, vld_base;
    logic [CNTW-1:0]       cnt_q, cnt_d, cnt_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                ent_q[i] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    // clear is applied to the base state first so a simultaneous load lands in an empty history
    always_comb begin
        vld_base = clear ? '0 : vld_q;
        cnt_base = clear ? '0 : cnt_q;
        ent_d    = ent_q;
        vld_d    = vld_base;
        cnt_d    = cnt_base;
        if (result_valid) begin
            ent_d[0] = result_in;
            vld_d[0] = 1'b1;
            for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
                ent_d[i] = ent_q[i-1];
                vld_d[i] = vld_base[i-1];
            end
            if (cnt_base != CNTW'(NUM_DIGITS)) begin
                cnt_d = cnt_base + 1'b1;
            end
        end
    end

    // ---------------- digit scan ----------------
    logic [PSW-1:0]  presc_q, presc_d;
    logic [IDXW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PSW'(SCAN_DIV-1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDXW'(NUM_DIGITS-1)) ? '0 : idx_q + 1'b1;
        end
    end

    // ---------------- output register ----------------
    logic [6:0]            seg_q, seg_d, seg_al;
    logic [NUM_DIGITS-1:0] an_q, an_d, an_al;
    logic [3:0]            sel_val;
    logic                  sel_vld;

    assign sel_val = ent_q[idx_q];
    assign sel_vld = vld_q[idx_q];

    always_comb begin
        an_al = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                an_al[i] = 1'b0;
            end
        end

        seg_al = SEG_BLANK;
        if (mode_q == MODE_STATUS) begin
            if (idx_q == '0) begin
                seg_al = hex7(status_code);
            end
        end else if (sel_vld) begin
            seg_al = (sel_val > 4'd9) ? SEG_DASH : hex7(sel_val);
        end

        seg_d = ACTIVE_LOW ? seg_al : ~seg_al;
        an_d  = ACTIVE_LOW ? an_al  : ~an_al;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    // ---------------- heartbeat ----------------
    logic [HBW-1:0] hb_cnt_q, hb_cnt_d;
    logic           hb_q, hb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

    always_comb begin
        hb_cnt_d = hb_cnt_q + 1'b1;
        hb_d     = hb_q;
        if (hb_cnt_q == HBW'(HB_DIV-1)) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end
    end

    assign seg           = seg_q;
    assign an            = an_q;
    assign heartbeat     = hb_q;
    assign history_count = cnt_q;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Randomized bench for result_display_ctrl, checked every cycle against a
// queue-based behavioural model plus directed literal expectations.
module tb_result_display_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int HD = 8;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       result_valid = 1'b0;
    logic [3:0] result_in = '0;
    logic [3:0] status_code = '0;
    logic       clear = 1'b0;
    logic       mode_sw = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       heartbeat;
    logic [2:0] history_count;

    int vectors = 0;
    int miscompares = 0;

    result_display_ctrl #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .HB_DIV(HD),
        .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .result_valid(result_valid),
        .result_in(result_in), .status_code(status_code), .clear(clear),
        .mode_sw(mode_sw), .seg(seg), .an(an), .heartbeat(heartbeat),
        .history_count(history_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input int v);
        case (v)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    int         hist[$];
    bit         m_mode, raw1, raw2, s;
    int         m_run, n, digit;
    logic [6:0] exp_seg = 7'h7F;
    logic [3:0] exp_an = 4'hF;
    logic       exp_hb = 1'b0;
    int         exp_cnt = 0;

    function automatic logic [6:0] model_seg(input int d);
        if (m_mode) return (d == 0) ? dec(int'(status_code)) : 7'b1111111;
        if (d >= hist.size()) return 7'b1111111;
        if (hist[d] > 9) return 7'b0111111;
        return dec(hist[d]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_mode = 0; m_run = 0; raw1 = 0; raw2 = 0; n = 0;
            exp_seg = 7'h7F; exp_an = 4'hF; exp_hb = 1'b0; exp_cnt = 0;
        end else begin
            digit   = (n / SD) % ND;
            exp_an  = ~(4'b0001 << digit);
            exp_seg = model_seg(digit);
            n++;
            exp_hb  = ((n / HD) % 2) == 1;
            if (clear) hist.delete();
            if (result_valid) begin
                hist.push_front(int'(result_in));
                if (hist.size() > ND) void'(hist.pop_back());
            end
            exp_cnt = hist.size();
            s = raw2; raw2 = raw1; raw1 = mode_sw;
            if (s != m_mode) begin
                m_run++;
                if (m_run == DB) begin
                    m_mode = ~m_mode;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("seg", 32'(seg), 32'(exp_seg));
        check("an", 32'(an), 32'(exp_an));
        check("heartbeat", 32'(heartbeat), 32'(exp_hb));
        check("history_count", 32'(history_count), 32'(exp_cnt));
    end

    // ---------------- directed helpers ----------------
    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic push(input int v);
        @(negedge clk);
        result_valid = 1'b1;
        result_in = 4'(v);
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic expect_digit(input string name, input int d, input logic [6:0] want);
        logic [3:0] target;
        bit found;
        target = ~(4'b0001 << d);
        found = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if (an == target) found = 1;
        end
        if (!found) check({name, "_timeout"}, 32'(an), 32'(target));
        else        check(name, 32'(seg), 32'(want));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // 1: idle scan and heartbeat
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            if (e == 1)  check("s1_an_e1", 32'(an), 32'h0E);
            if (e == 5)  check("s1_an_e5", 32'(an), 32'h0D);
            if (e == 9)  check("s1_an_e9", 32'(an), 32'h0B);
            if (e == 13) check("s1_an_e13", 32'(an), 32'h07);
            if (e == 7)  check("s1_hb_e7", 32'(heartbeat), 32'h0);
            if (e == 8)  check("s1_hb_e8", 32'(heartbeat), 32'h1);
            if (e == 16) check("s1_hb_e16", 32'(heartbeat), 32'h0);
            if (e == 20) check("s1_seg", 32'(seg), 32'h7F);
        end

        // 2: two results
        push(3); push(7); cycles(2);
        check("s2_count", 32'(history_count), 32'd2);
        expect_digit("s2_d0", 0, 7'b1111000);
        expect_digit("s2_d1", 1, 7'b0110000);
        expect_digit("s2_d2", 2, 7'b1111111);
        expect_digit("s2_d3", 3, 7'b1111111);

        // 3: overflow
        for (int v = 1; v <= 5; v++) push(v);
        cycles(2);
        check("s3_count", 32'(history_count), 32'd4);
        expect_digit("s3_d0", 0, 7'b0010010);
        expect_digit("s3_d1", 1, 7'b0011001);
        expect_digit("s3_d2", 2, 7'b0110000);
        expect_digit("s3_d3", 3, 7'b0100100);

        // 4: simultaneous clear and load
        @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0;
        push(3); push(7);
        @(negedge clk);
        clear = 1'b1; result_valid = 1'b1; result_in = 4'd9;
        @(negedge clk);
        clear = 1'b0; result_valid = 1'b0;
        cycles(1);
        check("s4_count", 32'(history_count), 32'd1);
        expect_digit("s4_d0", 0, 7'b0010000);
        expect_digit("s4_d1", 1, 7'b1111111);
        push(12); cycles(2);
        expect_digit("s4_dash", 0, 7'b0111111);
        expect_digit("s4_d1b", 1, 7'b0010000);

        // 5: debounce and status mode
        @(negedge clk); mode_sw = 1'b1;
        cycles(3); mode_sw = 1'b0;
        cycles(10);
        expect_digit("s5_glitch", 0, 7'b0111111);
        status_code = 4'hE; mode_sw = 1'b1;
        cycles(10);
        expect_digit("s5_status_d0", 0, 7'b0000110);
        expect_digit("s5_status_d1", 1, 7'b1111111);
        push(5);
        mode_sw = 1'b0;
        cycles(10);
        expect_digit("s5_back_d0", 0, 7'b0010010);
        expect_digit("s5_back_d1", 1, 7'b0111111);

        // 6: async reset mid-scan with full history
        for (int v = 0; v < 4; v++) push(v + 2);
        expect_digit("s6_pre", 2, 7'b0110000);
        #3 rst_n = 1'b0;
        #1;
        check("s6_seg_async", 32'(seg), 32'h7F);
        check("s6_an_async", 32'(an), 32'h0F);
        check("s6_cnt_async", 32'(history_count), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("s6_an_restart", 32'(an), 32'h0E);
        check("s6_cnt_restart", 32'(history_count), 32'd0);

        // random traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            result_valid = ($urandom_range(3) == 0);
            result_in    = 4'($urandom_range(15));
            clear        = ($urandom_range(39) == 0);
            status_code  = 4'($urandom_range(15));
            if ($urandom_range(15) == 0) mode_sw = ~mode_sw;
        end
        @(negedge clk);
        result_valid = 1'b0; clear = 1'b0;
        cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_display_ctrl.md
Name: result_display_ctrl

Overview:
Parametrised successor to the single-digit result display in the top-level controller. Holds a shift history of the last NUM_DIGITS BNN results and drives a time-multiplexed multi-digit 7-segment display with configurable polarity. Provides a debounced mode switch to show the FSM status code instead of the history, plus a divided heartbeat. Sits between bnn_interface/controller_fsm outputs and the board display pins.

Parameters:
NUM_DIGITS, 4, number of display digits and history depth (legal range 1..8)
SCAN_DIV, 1000, clk cycles each digit is lit (legal minimum 2)
HB_DIV, 25000000, clk cycles between heartbeat toggles (legal minimum 1)
DEBOUNCE_CYCLES, 16, consecutive stable synced samples required to accept a mode_sw change (legal minimum 1)
ACTIVE_LOW, 1, 1 means seg/an are active-low; 0 means active-high

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
result_valid  in  1  single-cycle pulse: result_in is a new classification
result_in  in  4  BNN result, 0..9 nominal
status_code  in  4  FSM status code, shown in status mode
clear  in  1  single-cycle pulse: empty the history
mode_sw  in  1  raw asynchronous switch; 0 = history mode, 1 = status mode
seg  out  7  segments {g,f,e,d,c,b,a}, registered
an  out  NUM_DIGITS  digit enables, one-hot, registered
heartbeat  out  1  toggles every HB_DIV cycles
history_count  out  $clog2(NUM_DIGITS+1)  number of valid history entries

Behaviour:
- Reset (async): all outputs are driven to the off level; outputs are not held at mid-state.
  - seg and an go all-off (all 1s when ACTIVE_LOW=1, all 0s otherwise).
  - heartbeat=0, history_count=0, all history valid bits=0, mode=history.
  - Scan index=0, prescaler=0, debounce counter=0, synchronizer flops=0.
- mode_sw conditioning:
  - Two-flop synchronizer, then a debounce counter.
  - The counter increments while the synced value differs from the accepted mode, and resets to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the value still differs, the accepted mode flips and the counter clears.
- History (entries 0..NUM_DIGITS-1; entry 0 = newest, shown on digit 0):
  - On result_valid: entry[0] <= result_in, entry[i] <= entry[i-1], valid bits shift the same way, and history_count increments, saturating at NUM_DIGITS.
  - Once full, the oldest entry falls off.
  - On clear: all valid bits=0, history_count=0.
  - clear and result_valid in the same cycle: clear applies first, then the load. Result: only entry 0 valid, holding result_in, history_count=1.
  - History updates continue while in status mode.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - On wrap, the scan index advances (NUM_DIGITS-1 wraps to 0).
  - With NUM_DIGITS=1 the index stays 0.
- Output register:
  - Every cycle, an <= one-hot(scan index) and seg <= decode(selected digit), both after polarity.
  - Latency: 1 cycle from an index or data change to the pins.
  - The first post-reset cycle drives digit 0.
- Decode, expressed active-low before polarity (0 means the segment is on):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - History mode, values 10..15: dash 0111111.
  - History mode, invalid entry: blank 1111111.
  - Status mode: digit 0 shows status_code in hex; A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. All other digits are blank.
- Polarity: when ACTIVE_LOW=0, seg and an are bitwise-inverted relative to the active-low form.
- Heartbeat: counter 0..HB_DIV-1; heartbeat toggles on wrap. It is independent of all other logic.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, HB_DIV=8, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
1. Reset then idle 40 cycles:
   - an cycles 1110, 1101, 1011, 0111, changing every 4 clocks.
   - seg=1111111 throughout; history_count=0.
   - heartbeat toggles every 8 clocks.
2. Push results 3, 7:
   - history_count=2.
   - When an=1110, seg=1111000 (shows 7). When an=1101, seg=0110000 (shows 3). Digits 2 and 3 are blank.
3. Push 1, 2, 3, 4, 5 (overflow):
   - history_count=4.
   - Digits 0..3 show 5, 4, 3, 2; the value 1 is discarded.
4. History holds 2 entries; pulse clear and result_valid (result_in=9) in the same cycle:
   - history_count=1, digit 0 shows 0010000 (9), digits 1..3 blank.
   - Push result_in=12: digit 0 shows dash 0111111, digit 1 shows 9.
5. Set mode_sw=1 for 3 synced cycles, then drop it:
   - Mode does not change.
   - Hold mode_sw=1 at least 6 cycles: status mode entered. status_code=4'hE gives digit 0 = 0000110 and other digits blank.
   - Push a result while in status mode; return to history mode: the new result is shown.
6. Assert rst_n low mid-scan (an=1011) while the history is full:
   - seg and an go all-1 immediately (asynchronously).
   - After release: history_count=0, scan restarts at digit 0, mode=history.
